// File: rtl/cache_pkg.sv
// Shared types and default widths for the data-cache miss path.
package cache_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned RAM_ADDR_WIDTH = 32;
  localparam int unsigned BYTE_OFFSET    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StRefill,
    StUpdate
  } miss_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_miss_sequencer.sv
// Miss handler for the two-way data cache: stalls the pipeline, writes back a
// dirty victim, refills the missing word from RAM and hands it back for commit.
module cache_miss_sequencer #(
  parameter int unsigned DATA_WIDTH     = cache_pkg::DATA_WIDTH,
  parameter int unsigned RAM_ADDR_WIDTH = cache_pkg::RAM_ADDR_WIDTH,
  parameter int unsigned BYTE_OFFSET    = cache_pkg::BYTE_OFFSET,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      access_valid,
  input  logic                      hit,
  input  logic                      evict_dirty,
  input  logic [RAM_ADDR_WIDTH-1:0] evict_addr,
  input  logic [DATA_WIDTH-1:0]     evict_data,
  input  logic [RAM_ADDR_WIDTH-1:0] miss_addr,
  input  logic                      ram_ready,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  output logic                      stall,
  output logic                      ram_req,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  output logic                      fill_valid,
  output logic [DATA_WIDTH-1:0]     fill_data,
  output logic [CNT_WIDTH-1:0]      miss_count,
  output logic [CNT_WIDTH-1:0]      wb_count
);

  import cache_pkg::*;

  miss_state_e state_q, state_d;

  logic [RAM_ADDR_WIDTH-1:0] evict_addr_q, miss_addr_q;
  logic [DATA_WIDTH-1:0]     evict_data_q, fill_data_q;
  logic                      dirty_q;
  logic                      miss, miss_start, wb_done;

  assign miss       = access_valid & ~hit;
  assign miss_start = (state_q == StIdle) & miss;
  assign wb_done    = (state_q == StWriteback) & ram_ready & dirty_q;

  // Transaction operands are captured once at the miss; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      evict_addr_q <= '0;
      evict_data_q <= '0;
      miss_addr_q  <= '0;
      dirty_q      <= 1'b0;
      fill_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        evict_addr_q <= {evict_addr[RAM_ADDR_WIDTH-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};
        evict_data_q <= evict_data;
        miss_addr_q  <= {miss_addr[RAM_ADDR_WIDTH-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};
        dirty_q      <= evict_dirty;
      end
      if ((state_q == StRefill) && ram_ready) begin
        fill_data_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (miss) state_d = evict_dirty ? StWriteback : StRefill;
      StWriteback: if (ram_ready) state_d = StRefill;
      StRefill:    if (ram_ready) state_d = StUpdate;
      StUpdate:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    stall      = 1'b1;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    fill_valid = 1'b0;
    unique case (state_q)
      StIdle: stall = miss;
      StWriteback: begin
        ram_req   = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = evict_addr_q;
        ram_wdata = evict_data_q;
      end
      StRefill: begin
        ram_req  = 1'b1;
        ram_addr = miss_addr_q;
      end
      StUpdate: fill_valid = 1'b1;
      default: ;
    endcase
  end

  assign fill_data = fill_data_q;

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_miss_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (miss_start),
    .count(miss_count)
  );

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_wb_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (wb_done),
    .count(wb_count)
  );

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed bench for cache_miss_sequencer; a second 4-bit-counter instance
// shares the stimulus so counter saturation is reachable in a short run.
module tb_cache_miss_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        access_valid, hit, evict_dirty, ram_ready;
  logic [31:0] evict_addr, evict_data, miss_addr, ram_rdata;

  logic        stall, ram_req, ram_we, fill_valid;
  logic [31:0] ram_addr, ram_wdata, fill_data;
  logic [15:0] miss_count, wb_count;

  logic        s_stall, s_ram_req, s_ram_we, s_fill_valid;
  logic [31:0] s_ram_addr, s_ram_wdata, s_fill_data;
  logic [3:0]  s_miss_count, s_wb_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_miss_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .access_valid(access_valid),
    .hit         (hit),
    .evict_dirty (evict_dirty),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .miss_addr   (miss_addr),
    .ram_ready   (ram_ready),
    .ram_rdata   (ram_rdata),
    .stall       (stall),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .miss_count  (miss_count),
    .wb_count    (wb_count)
  );

  cache_miss_sequencer #(
    .CNT_WIDTH(4)
  ) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .access_valid(access_valid),
    .hit         (hit),
    .evict_dirty (evict_dirty),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .miss_addr   (miss_addr),
    .ram_ready   (ram_ready),
    .ram_rdata   (ram_rdata),
    .stall       (s_stall),
    .ram_req     (s_ram_req),
    .ram_we      (s_ram_we),
    .ram_addr    (s_ram_addr),
    .ram_wdata   (s_ram_wdata),
    .fill_valid  (s_fill_valid),
    .fill_data   (s_fill_data),
    .miss_count  (s_miss_count),
    .wb_count    (s_wb_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_stall, input logic e_req,
                         input logic e_we, input logic [31:0] e_addr,
                         input logic [31:0] e_wdata, input logic e_fv);
    check({tag, ".stall"}, 64'(stall), 64'(e_stall));
    check({tag, ".ram_req"}, 64'(ram_req), 64'(e_req));
    check({tag, ".ram_we"}, 64'(ram_we), 64'(e_we));
    check({tag, ".ram_addr"}, 64'(ram_addr), 64'(e_addr));
    check({tag, ".ram_wdata"}, 64'(ram_wdata), 64'(e_wdata));
    check({tag, ".fill_valid"}, 64'(fill_valid), 64'(e_fv));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    access_valid = 1'b0; hit = 1'b0; evict_dirty = 1'b0; ram_ready = 1'b0;
    evict_addr = '0; evict_data = '0; miss_addr = '0; ram_rdata = '0;

    // Reset state
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    check("reset.fill_data", 64'(fill_data), 64'h0);
    check("reset.miss_count", 64'(miss_count), 64'h0);
    check("reset.wb_count", 64'(wb_count), 64'h0);
    #2 rst_n = 1'b1;
    cyc();

    // Hits never stall
    for (int i = 0; i < 5; i++) begin
      access_valid = 1'b1; hit = 1'b1; miss_addr = 32'h100 + 32'(i);
      @(negedge clk);
      chk_out("hit", 0, 0, 0, 0, 0, 0);
      cyc();
    end
    check("hit.miss_count", 64'(miss_count), 64'h0);

    // Clean miss, RAM ready after two wait cycles
    hit = 1'b0; evict_dirty = 1'b0; miss_addr = 32'h0000_1236;
    evict_addr = 32'h0000_5550; evict_data = 32'hAAAA_AAAA;
    @(negedge clk);
    chk_out("clean.miss", 1, 0, 0, 0, 0, 0);
    cyc();
    access_valid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      ram_ready = (w == 2);
      ram_rdata = (w == 2) ? 32'hDEAD_BEEF : 32'h1111_1111;
      @(negedge clk);
      chk_out("clean.refill", 1, 1, 0, 32'h0000_1234, 0, 0);
      cyc();
    end
    ram_ready = 1'b0;
    @(negedge clk);
    chk_out("clean.update", 1, 0, 0, 0, 0, 1);
    check("clean.fill_data", 64'(fill_data), 64'hDEAD_BEEF);
    cyc();
    access_valid = 1'b1; hit = 1'b1;
    @(negedge clk);
    chk_out("clean.replay", 0, 0, 0, 0, 0, 0);
    check("clean.miss_count", 64'(miss_count), 64'h1);
    check("clean.wb_count", 64'(wb_count), 64'h0);
    cyc();

    // Input churn during refill is ignored
    hit = 1'b0; miss_addr = 32'h0000_1234;
    @(negedge clk);
    check("churn.miss_stall", 64'(stall), 64'h1);
    cyc();
    access_valid = 1'b0; hit = 1'b1; miss_addr = 32'h0000_9990;
    @(negedge clk);
    chk_out("churn.refill0", 1, 1, 0, 32'h0000_1234, 0, 0);
    cyc();
    access_valid = 1'b1; hit = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk_out("churn.refill1", 1, 1, 0, 32'h0000_1234, 0, 0);
    cyc();
    access_valid = 1'b0; ram_ready = 1'b0;
    @(negedge clk);
    chk_out("churn.update", 1, 0, 0, 0, 0, 1);
    check("churn.fill_data", 64'(fill_data), 64'h0BAD_F00D);
    cyc();
    @(negedge clk);
    chk_out("churn.idle", 0, 0, 0, 0, 0, 0);
    check("churn.miss_count", 64'(miss_count), 64'h2);
    cyc();

    // Dirty miss, RAM always ready: WRITEBACK, REFILL, UPDATE
    access_valid = 1'b1; hit = 1'b0; evict_dirty = 1'b1;
    evict_addr = 32'h0000_2000; evict_data = 32'h1234_5678; miss_addr = 32'h0000_4448;
    ram_ready = 1'b1; ram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk_out("dirty.miss", 1, 0, 0, 0, 0, 0);
    cyc();
    access_valid = 1'b0; evict_dirty = 1'b0; evict_addr = 32'hFFFF_0000;
    evict_data = 32'h0;
    @(negedge clk);
    chk_out("dirty.wb", 1, 1, 1, 32'h0000_2000, 32'h1234_5678, 0);
    cyc();
    @(negedge clk);
    chk_out("dirty.refill", 1, 1, 0, 32'h0000_4448, 0, 0);
    cyc();
    @(negedge clk);
    chk_out("dirty.update", 1, 0, 0, 0, 0, 1);
    check("dirty.fill_data", 64'(fill_data), 64'hCAFE_F00D);
    cyc();
    access_valid = 1'b1; hit = 1'b1;
    @(negedge clk);
    chk_out("dirty.replay", 0, 0, 0, 0, 0, 0);
    check("dirty.wb_count", 64'(wb_count), 64'h1);
    check("dirty.miss_count", 64'(miss_count), 64'h3);
    check("dirty.small_miss_count", 64'(s_miss_count), 64'h3);
    cyc();

    // Asynchronous reset while in WRITEBACK
    hit = 1'b0; evict_dirty = 1'b1; ram_ready = 1'b0; evict_addr = 32'h0000_3000;
    @(negedge clk);
    check("rst.miss_stall", 64'(stall), 64'h1);
    cyc();
    access_valid = 1'b0; evict_dirty = 1'b0;
    @(negedge clk);
    chk_out("rst.wb", 1, 1, 1, 32'h0000_3000, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst.async", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst.miss_count", 64'(miss_count), 64'h0);
    check("rst.wb_count", 64'(wb_count), 64'h0);
    check("rst.fill_data", 64'(fill_data), 64'h0);
    #2 rst_n = 1'b1;
    cyc();
    ram_ready = 1'b1;
    @(negedge clk);
    chk_out("rst.idle_ready", 0, 0, 0, 0, 0, 0);
    cyc();
    ram_ready = 1'b0;
    @(negedge clk);
    chk_out("rst.after_ready", 0, 0, 0, 0, 0, 0);
    cyc();

    // Back-to-back clean misses with stray ram_ready pulses in IDLE
    for (int i = 0; i < 20; i++) begin
      access_valid = 1'b1; hit = 1'b0; evict_dirty = 1'b0;
      miss_addr = 32'(i) << 4; ram_ready = 1'b1; ram_rdata = 32'(i) + 32'h100;
      @(negedge clk);
      check("sat.miss_stall", 64'(s_stall), 64'h1);
      check("sat.miss_req", 64'(ram_req), 64'h0);
      cyc();
      access_valid = 1'b0;
      @(negedge clk);
      check("sat.refill_req", 64'(s_ram_req), 64'h1);
      check("sat.refill_addr", 64'(ram_addr), 64'(32'(i) << 4));
      cyc();
      @(negedge clk);
      check("sat.fill_data", 64'(fill_data), 64'(32'(i) + 32'h100));
      cyc();
      @(negedge clk);
      check("sat.idle_req", 64'(ram_req), 64'h0);
      check("sat.miss_count", 64'(miss_count), 64'(i + 1));
      check("sat.small_count", 64'(s_miss_count), (i + 1 > 15) ? 64'd15 : 64'(i + 1));
      cyc();
    end
    ram_ready = 1'b0;
    @(negedge clk);
    check("sat.small_final", 64'(s_miss_count), 64'hF);
    check("sat.small_wb", 64'(s_wb_count), 64'h0);
    check("sat.wb_count", 64'(wb_count), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
